alert_scheduler: RTL
====================

ALERT_SCHEDULER -- requirements
Module: alert_scheduler

Interface
REQ-001 Parameter ALARM_TOGGLES, 120, number of Light toggles in one alarm burst (1..255).
REQ-002 Parameter ALARM_EN_DEFAULT, 0, value of the internal alarm-armed flag after reset.
REQ-003 CLK  input  1  single system clock, all state on rising edge.
REQ-004 RST_N  input  1  reset, asynchronous, active-low.
REQ-005 TICK  input  1  one-CLK-wide blink-rate strobe; every Light toggle and count step is qualified by it.
REQ-006 Hour  input  8  current hour, packed BCD 00..23.
REQ-007 Minute  input  8  current minute, packed BCD 00..59.
REQ-008 Second  input  8  current second, packed BCD 00..59.
REQ-009 AlarmHour  input  8  alarm hour, packed BCD.
REQ-010 AlarmMinute  input  8  alarm minute, packed BCD.
REQ-011 ArmToggle  input  1  one-CLK pulse; inverts alarm-armed flag.
REQ-012 Stop  input  1  one-CLK pulse; aborts the active burst.
REQ-013 Light  output  1  shared indicator driven by the active source.
REQ-014 Busy  output  1  high while a burst (chime or alarm) is active.
REQ-015 Source  output  2  owner of Light: 00 none, 01 chime, 10 alarm.
REQ-016 Armed  output  1  current alarm-armed flag.

Function
REQ-017 Block SHALL implement states IDLE, CHIME, ALARM; Source encodes state (IDLE=00, CHIME=01, ALARM=10).
REQ-018 Chime event SHALL fire on the first CLK where Minute==00 and Second==00, detected by registered match edge so it fires once per hour.
REQ-019 Alarm event SHALL fire on the first CLK where Armed=1, Hour==AlarmHour, Minute==AlarmMinute, Second==00, edge-detected likewise.
REQ-020 Chime flash count N SHALL be Hour converted BCD-to-binary, with Hour==00 mapped to 24; Light toggles 2N times.
REQ-021 On chime event in IDLE: next CLK state=CHIME, counter loaded 2N, Light=0; each TICK toggles Light and decrements counter; at counter 0 on a TICK, state=IDLE, Light=0.
REQ-022 On alarm event in IDLE or CHIME: next CLK state=ALARM, counter loaded ALARM_TOGGLES, Light=0; chime in progress SHALL be discarded, not resumed.
REQ-023 Simultaneous chime and alarm events SHALL select ALARM; chime dropped.
REQ-024 Chime event while in CHIME or ALARM SHALL be ignored.
REQ-025 ALARM toggles Light per TICK until counter reaches 0, then IDLE, Light=0.
REQ-026 Stop in CHIME or ALARM SHALL force IDLE, Light=0, counter=0 on the next CLK; Stop in IDLE has no effect.
REQ-027 ArmToggle SHALL invert Armed on the next CLK; disarming in ALARM SHALL behave as Stop.
REQ-028 Stop and alarm event on the same CLK: event wins (new alarm burst starts).
REQ-029 Busy SHALL equal (state != IDLE), registered; Light SHALL be 0 whenever state==IDLE.
REQ-030 Counter SHALL be 8 bits unsigned; 2N max 48 and ALARM_TOGGLES max 255 never overflow; decrement never wraps below 0.
REQ-031 Non-BCD or out-of-range time inputs SHALL not cause lockup; conversion result simply used.

Reset
REQ-032 RST_N low SHALL immediately force state=IDLE, counter=0, Light=0, Busy=0, Source=00, Armed=ALARM_EN_DEFAULT, match-edge registers=1 (no event fires at release if time already at :00:00).
REQ-033 Reset mid-burst SHALL abort with no resumption after release.

Structure
REQ-034 Package alert_pkg SHALL hold state/Source encodings (SRC_NONE, SRC_CHIME, SRC_ALARM) and counter width constant.
REQ-035 BCD-to-binary conversion SHALL be sub-module bcd_to_bin (8-bit packed BCD in, 8-bit binary out, combinational: tens*10+units).

Verification
REQ-036 Hour=13, Minute 59->00, Second=00, TICK every 4 CLK -> Source=01, exactly 26 Light toggles, then Busy=0, Light=0.
REQ-037 Hour=00 chime -> 48 toggles; Minute/Second held at 00 for 100 CLK -> no second chime.
REQ-038 Armed=1, Alarm=07:30, time reaches 07:30:00 -> Source=10, 120 toggles with default ALARM_TOGGLES, then IDLE.
REQ-039 Alarm=12:00, time reaches 12:00:00 -> ALARM only, no chime afterwards; chime at 11:00 interrupted by alarm at 11:00 identical result.
REQ-040 Stop after 5 alarm toggles -> next CLK Light=0, Busy=0; ArmToggle during ALARM -> Armed=0 and IDLE.
REQ-041 RST_N asserted mid-CHIME asynchronously -> Light=0 before next CLK edge; release at 09:00:00 -> no chime.

Source files
------------

// File: rtl/alert_pkg.sv
// Shared encodings and widths for the alert scheduler.
// Source/state values double as the Light-owner code.
package alert_pkg;

    localparam int CNT_W = 8;

    localparam logic [1:0] SRC_NONE  = 2'b00;
    localparam logic [1:0] SRC_CHIME = 2'b01;
    localparam logic [1:0] SRC_ALARM = 2'b10;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/bcd_to_bin.sv
// Packed BCD byte to binary: tens*10 + units.
// Non-BCD nibbles are converted arithmetically.
module bcd_to_bin (
    input  logic [7:0] bcd,
    output logic [7:0] bin
);

    logic [7:0] tens;
    logic [7:0] units;

    assign tens  = {4'd0, bcd[7:4]};
    assign units = {4'd0, bcd[3:0]};
    assign bin   = (tens * 8'd10) + units;

endmodule

// File: rtl/alert_scheduler.sv
// Hourly chime / alarm arbiter for one shared Light.
// Alarm pre-empts chime; Stop or disarm aborts a burst.
module alert_scheduler
    import alert_pkg::*;
#(
    parameter int ALARM_TOGGLES    = 120,
    parameter bit ALARM_EN_DEFAULT = 1'b0
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       TICK,
    input  logic [7:0] Hour,
    input  logic [7:0] Minute,
    input  logic [7:0] Second,
    input  logic [7:0] AlarmHour,
    input  logic [7:0] AlarmMinute,
    input  logic       ArmToggle,
    input  logic       Stop,
    output logic       Light,
    output logic       Busy,
    output logic [1:0] Source,
    output logic       Armed
);

    localparam cnt_t ALARM_LOAD = cnt_t'(ALARM_TOGGLES);

    logic [1:0] state;
    cnt_t       cnt;
    logic       light_q;
    logic       armed_q;
    logic       chime_q;
    logic       alarm_q;

    logic [7:0] hour_bin;
    logic [7:0] chime_n;
    cnt_t       chime_load;

    logic top_of_hour;
    logic chime_m;
    logic alarm_m;
    logic chime_ev;
    logic alarm_ev;
    logic abort;
    logic active;

    bcd_to_bin u_hour (
        .bcd (Hour),
        .bin (hour_bin)
    );

    // Midnight flashes 24 times rather than zero.
    assign chime_n    = (hour_bin == 8'd0) ? 8'd24 : hour_bin;
    assign chime_load = {chime_n[6:0], 1'b0};

    assign top_of_hour = (Minute == 8'h00) && (Second == 8'h00);
    assign chime_m     = top_of_hour;
    assign alarm_m     = armed_q
                      && (Hour == AlarmHour)
                      && (Minute == AlarmMinute)
                      && (Second == 8'h00);

    assign chime_ev = chime_m && !chime_q;
    assign alarm_ev = alarm_m && !alarm_q;

    assign active = (state != SRC_NONE);
    assign abort  = Stop
                 || (ArmToggle && armed_q
                     && (state == SRC_ALARM));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= SRC_NONE;
            cnt     <= '0;
            light_q <= 1'b0;
            armed_q <= ALARM_EN_DEFAULT;
            chime_q <= 1'b1;
            alarm_q <= 1'b1;
        end else begin
            chime_q <= chime_m;
            alarm_q <= alarm_m;
            if (ArmToggle) begin
                armed_q <= ~armed_q;
            end
            if (alarm_ev) begin
                state   <= SRC_ALARM;
                cnt     <= ALARM_LOAD;
                light_q <= 1'b0;
            end else if (abort && active) begin
                state   <= SRC_NONE;
                cnt     <= '0;
                light_q <= 1'b0;
            end else if (chime_ev && !active) begin
                state   <= SRC_CHIME;
                cnt     <= chime_load;
                light_q <= 1'b0;
            end else if (TICK && active) begin
                if (cnt == '0) begin
                    state   <= SRC_NONE;
                    light_q <= 1'b0;
                end else begin
                    light_q <= ~light_q;
                    cnt     <= cnt - 1'b1;
                end
            end
        end
    end

    assign Light  = light_q;
    assign Busy   = active;
    assign Source = state;
    assign Armed  = armed_q;

endmodule
